// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback pending buffer.
// Each entry carries 64 data bits and a 128-bit PTC made of 8 byte slices of 16 bits.
package wb_pkg;

  localparam int WB_DATA_W     = 64;
  localparam int WB_PTC_W      = 128;
  localparam int WB_BYTES      = 8;
  localparam int WB_BYTE_PTC_W = 16;

  // One byte's PTC tag; all-zero means the byte is not written.
  typedef logic [WB_BYTE_PTC_W-1:0] byte_ptc_t;

  // A full entry PTC viewed as its byte slices (slice b at [16b+15:16b]).
  typedef byte_ptc_t [WB_BYTES-1:0] entry_ptc_t;

endpackage

// File: rtl/wb_supersede_slice.sv
// Clears every byte slice of one stored PTC whose tag matches any nonzero
// slice of the incoming PTC, so the newest writer owns each byte.
module wb_supersede_slice
  import wb_pkg::*;
(
  input  logic [WB_PTC_W-1:0] stored_ptc,
  input  logic [WB_PTC_W-1:0] in_ptc,
  output logic [WB_PTC_W-1:0] cleared_ptc
);

  entry_ptc_t stored_s;
  entry_ptc_t in_s;
  entry_ptc_t cleared_s;

  assign stored_s = stored_ptc;
  assign in_s     = in_ptc;

  // Compare every stored slice against every incoming slice.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred latches.
    cleared_s = stored_s;
    for (int b = 0; b < WB_BYTES; b++) begin
      for (int c = 0; c < WB_BYTES; c++) begin
        if ((in_s[c] != '0) && (stored_s[b] == in_s[c])) begin
          cleared_s[b] = '0;
        end
      end
    end
  end

  assign cleared_ptc = cleared_s;

endmodule

// File: rtl/wb_pending_buffer.sv
// Circular buffer of committed-but-not-yet-written 64-bit writebacks.
// Feeds the bypass stage with every slot's data/PTC and drains entries in
// order to the memory write port. Incoming writes zero matching byte PTCs in
// older live entries, so no nonzero byte-PTC is ever held twice.
// Optional build macro WB_PENDING_OCCUPANCY_EN adds occupancy and a saturating
// superseded-slice counter.
module wb_pending_buffer
  import wb_pkg::*;
#(
  parameter  int NUM_PROSPECTS = 4,
  localparam int PTR_W         = $clog2(NUM_PROSPECTS)
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WB_DATA_W-1:0]              in_data,
  input  logic [WB_PTC_W-1:0]               in_ptc,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WB_DATA_W-1:0]              out_data,
  output logic [WB_PTC_W-1:0]               out_ptc,
  output logic [NUM_PROSPECTS*WB_DATA_W-1:0] prospective_data,
  output logic [NUM_PROSPECTS*WB_PTC_W-1:0]  prospective_ptc
`ifdef WB_PENDING_OCCUPANCY_EN
  ,
  output logic [PTR_W:0]                    occupancy,
  output logic [15:0]                       superseded_cnt
`endif
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(NUM_PROSPECTS);

  logic [WB_DATA_W-1:0]     data_q [NUM_PROSPECTS];
  logic [WB_PTC_W-1:0]      ptc_q  [NUM_PROSPECTS];
  logic [WB_PTC_W-1:0]      cleared_ptc [NUM_PROSPECTS];
  logic [NUM_PROSPECTS-1:0] valid_q;
  logic [NUM_PROSPECTS-1:0] supersede_en;
  logic [PTR_W-1:0]         head_q;
  logic [PTR_W-1:0]         tail_q;
  logic [PTR_W:0]           count_q;
  logic                     head_empty;
  logic                     push;
  logic                     pop;

  // A head entry whose slices were all superseded is dropped without a memory write.
  assign head_empty = (ptc_q[head_q] == '0);
  assign in_ready   = (count_q != FULL_COUNT);
  assign out_valid  = (count_q != '0) && !head_empty;
  assign pop        = (count_q != '0) && (head_empty || out_ready);
  assign push       = in_valid && in_ready;
  assign out_data   = data_q[head_q];
  assign out_ptc    = ptc_q[head_q];

  for (genvar i = 0; i < NUM_PROSPECTS; i++) begin : g_slot
    wb_supersede_slice u_supersede (
      .stored_ptc  (ptc_q[i]),
      .in_ptc      (in_ptc),
      .cleared_ptc (cleared_ptc[i])
    );

    // The slot leaving this cycle is written to memory unmodified.
    assign supersede_en[i] = push && valid_q[i] && !(pop && (head_q == PTR_W'(i)));

    assign prospective_data[i*WB_DATA_W +: WB_DATA_W] = data_q[i];
    assign prospective_ptc[i*WB_PTC_W +: WB_PTC_W]    = ptc_q[i];
  end

  // Slot storage, pointers and occupancy; flush behaves like a synchronous reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      // NOTE: the data array is cleared too so every flop has a defined reset value.
      for (int i = 0; i < NUM_PROSPECTS; i++) begin
        data_q[i] <= '0;
        ptc_q[i]  <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < NUM_PROSPECTS; i++) begin
        ptc_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let later writes to the same slot win cleanly.
      for (int i = 0; i < NUM_PROSPECTS; i++) begin
        if (supersede_en[i]) begin
          ptc_q[i] <= cleared_ptc[i];
        end
      end
      if (pop) begin
        ptc_q[head_q]   <= '0;
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push) begin
        data_q[tail_q]  <= in_data;
        ptc_q[tail_q]   <= in_ptc;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

`ifdef WB_PENDING_OCCUPANCY_EN
  logic [15:0] superseded_q;
  logic [15:0] sup_events;
  logic [16:0] sup_sum;

  // Count live slices that go from nonzero to zero on this edge.
  always_comb begin
    sup_events = '0;
    for (int i = 0; i < NUM_PROSPECTS; i++) begin
      for (int b = 0; b < WB_BYTES; b++) begin
        if (supersede_en[i] &&
            (ptc_q[i][b*WB_BYTE_PTC_W +: WB_BYTE_PTC_W] != '0) &&
            (cleared_ptc[i][b*WB_BYTE_PTC_W +: WB_BYTE_PTC_W] == '0)) begin
          sup_events = sup_events + 16'd1;
        end
      end
    end
    sup_sum = {1'b0, superseded_q} + {1'b0, sup_events};
  end

  // Saturating superseded-slice counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      superseded_q <= '0;
    end else if (flush) begin
      superseded_q <= '0;
    end else begin
      superseded_q <= sup_sum[16] ? 16'hFFFF : sup_sum[15:0];
    end
  end

  assign occupancy      = count_q;
  assign superseded_cnt = superseded_q;
`endif

endmodule

// File: tb/tb_wb_pending_buffer.sv
// Self-checking bench for wb_pending_buffer: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_wb_pending_buffer;

  localparam int N = 4;

  logic           clk;
  logic           clr;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [63:0]    in_data;
  logic [127:0]   in_ptc;
  logic           out_valid;
  logic           out_ready;
  logic [63:0]    out_data;
  logic [127:0]   out_ptc;
  logic [N*64-1:0]  prospective_data;
  logic [N*128-1:0] prospective_ptc;
`ifdef WB_PENDING_OCCUPANCY_EN
  logic [2:0]     occupancy;
  logic [15:0]    superseded_cnt;
`endif

  wb_pending_buffer #(.NUM_PROSPECTS(N)) dut (
    .clk              (clk),
    .clr              (clr),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_ptc           (in_ptc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_ptc          (out_ptc),
    .prospective_data (prospective_data),
    .prospective_ptc  (prospective_ptc)
`ifdef WB_PENDING_OCCUPANCY_EN
    ,
    .occupancy        (occupancy),
    .superseded_cnt   (superseded_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of live entries, oldest first, each tagged with its slot.
  typedef struct {
    int           slot;
    logic [63:0]  data;
    logic [127:0] ptc;
  } ent_t;

  ent_t        q[$];
  int          m_tail;
  int          m_sup;
  logic [63:0] dut_xfers[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] slice_ptc(input int b, input logic [15:0] v);
    logic [127:0] r;
    r = '0;
    r[b*16 +: 16] = v;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    m_sup  = 0;
  endtask

  // Apply one clock edge's worth of the buffer's rules to the model.
  task automatic model_step(input logic v, input logic [63:0] d, input logic [127:0] p,
                            input logic ordy, input logic fl);
    bit pop;
    bit push;
    int first;
    if (fl) begin
      model_reset();
      return;
    end
    pop  = (q.size() != 0) && ((q[0].ptc == '0) || ordy);
    push = v && (q.size() < N);
    if (push) begin
      first = pop ? 1 : 0;
      for (int k = first; k < q.size(); k++) begin
        ent_t e;
        e = q[k];
        for (int b = 0; b < 8; b++) begin
          logic [15:0] s;
          bit hit;
          s   = e.ptc[b*16 +: 16];
          hit = 0;
          for (int c = 0; c < 8; c++) begin
            if ((s != 16'h0) && (p[c*16 +: 16] == s)) hit = 1;
          end
          if (hit) begin
            e.ptc[b*16 +: 16] = 16'h0;
            m_sup++;
          end
        end
        q[k] = e;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back('{m_tail, d, p});
      m_tail = (m_tail + 1) % N;
    end
  endtask

  // Compare every DUT output against the model's view of the current state.
  task automatic check_outputs();
    logic [511:0] e_pptc;
    logic [255:0] e_pdata;
    logic [255:0] mask;
    e_pptc  = '0;
    e_pdata = '0;
    mask    = '0;
    foreach (q[k]) begin
      e_pptc[q[k].slot*128 +: 128] = q[k].ptc;
      e_pdata[q[k].slot*64 +: 64]  = q[k].data;
      mask[q[k].slot*64 +: 64]     = '1;
    end
    check("in_ready", 512'(in_ready), 512'(q.size() < N));
    if (q.size() != 0) begin
      check("out_valid", 512'(out_valid), 512'(q[0].ptc != '0));
      check("out_ptc", 512'(out_ptc), 512'(q[0].ptc));
      if (q[0].ptc != '0) check("out_data", 512'(out_data), 512'(q[0].data));
    end else begin
      check("out_valid", 512'(out_valid), 512'(0));
      check("out_ptc", 512'(out_ptc), 512'(0));
    end
    check("prospective_ptc", prospective_ptc, e_pptc);
    check("prospective_data", 512'(prospective_data & mask), 512'(e_pdata));
`ifdef WB_PENDING_OCCUPANCY_EN
    check("occupancy", 512'(occupancy), 512'(q.size()));
    check("superseded_cnt", 512'(superseded_cnt), 512'(m_sup));
`endif
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model.
  task automatic cycle(input logic v, input logic [63:0] d, input logic [127:0] p,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_ptc    = p;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    if (out_valid && out_ready && !fl) dut_xfers.push_back(out_data);
    @(posedge clk);
    model_step(v, d, p, ordy, fl);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 64'h0, 128'h0, ordy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  d;
    logic [127:0] p;
    int           hits;

    clr       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ptc    = '0;
    out_ready = 1'b0;
    model_reset();

    // Reset state, then idle.
    #12;
    check("reset_in_ready", 512'(in_ready), 512'(1));
    check("reset_out_valid", 512'(out_valid), 512'(0));
    check("reset_pptc", prospective_ptc, 512'(0));
    check("reset_out_ptc", 512'(out_ptc), 512'(0));
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 5; i++) idle(1'b0);

    // Fill with distinct PTCs while memory stalls, then drain in order.
    cycle(1'b1, 64'h1111_0000_0000_0001, slice_ptc(0, 16'h0001), 1'b0, 1'b0);
    cycle(1'b1, 64'h2222_0000_0000_0002, slice_ptc(1, 16'h0002), 1'b0, 1'b0);
    cycle(1'b1, 64'h3333_0000_0000_0003, slice_ptc(2, 16'h0010), 1'b0, 1'b0);
    cycle(1'b1, 64'h4444_0000_0000_0004, slice_ptc(3, 16'h0020), 1'b0, 1'b0);
    check("fill_in_ready", 512'(in_ready), 512'(0));
    dut_xfers.delete();
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("drain_count", 512'(dut_xfers.size()), 512'(4));
    if (dut_xfers.size() == 4) begin
      check("drain_order0", 512'(dut_xfers[0]), 512'(64'h1111_0000_0000_0001));
      check("drain_order3", 512'(dut_xfers[3]), 512'(64'h4444_0000_0000_0004));
    end
    check("drain_empty", 512'(out_valid), 512'(0));

    // Supersede: B takes byte PTC 0x0042 away from A (slot 0 -> slot 1).
    cycle(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, slice_ptc(0, 16'h0042) | slice_ptc(1, 16'h0043), 1'b0, 1'b0);
    cycle(1'b1, 64'hBBBB_BBBB_BBBB_BBBB, slice_ptc(3, 16'h0042), 1'b0, 1'b0);
    check("sup_a_slice0", 512'(prospective_ptc[15:0]), 512'(0));
    check("sup_b_slice3", 512'(prospective_ptc[128+48 +: 16]), 512'(16'h0042));
    hits = 0;
    for (int s = 0; s < N * 8; s++) if (prospective_ptc[s*16 +: 16] == 16'h0042) hits++;
    check("sup_unique", 512'(hits), 512'(1));
    check("sup_head_ptc", 512'(out_ptc), 512'(slice_ptc(1, 16'h0043)));
`ifdef WB_PENDING_OCCUPANCY_EN
    check("sup_cnt_one", 512'(superseded_cnt), 512'(1));
`endif
    idle(1'b1);
    idle(1'b1);

    // Fully superseded entry is dropped silently; only B reaches memory.
    dut_xfers.delete();
    cycle(1'b1, 64'hC0C0_C0C0_C0C0_C0C0, slice_ptc(0, 16'h0007), 1'b0, 1'b0);
    cycle(1'b1, 64'hD0D0_D0D0_D0D0_D0D0, slice_ptc(0, 16'h0007), 1'b0, 1'b0);
    check("silent_no_valid", 512'(out_valid), 512'(0));
    idle(1'b0);
    idle(1'b1);
    check("silent_xfers", 512'(dut_xfers.size()), 512'(1));
    if (dut_xfers.size() == 1) check("silent_first_is_b", 512'(dut_xfers[0]), 512'(64'hD0D0_D0D0_D0D0_D0D0));

    // Full with simultaneous handshake: dequeue happens, enqueue refused.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 64'(i + 16'h500), slice_ptc(i, 16'(16'h100 + i)), 1'b0, 1'b0);
    cycle(1'b1, 64'hEEEE, slice_ptc(7, 16'h0999), 1'b1, 1'b0);
    check("full_after_pop", 512'(in_ready), 512'(1));
    check("full_refused", 512'(prospective_ptc & {N{slice_ptc(7, 16'hFFFF)}}), 512'(0));
    cycle(1'b1, 64'hEEEE, slice_ptc(7, 16'h0999), 1'b0, 1'b0);
    check("full_accept", 512'(in_ready), 512'(0));

    // Flush beats a simultaneous enqueue and dequeue.
    dut_xfers.delete();
    cycle(1'b1, 64'hF00D, slice_ptc(2, 16'h0777), 1'b1, 1'b1);
    check("flush_pptc", prospective_ptc, 512'(0));
    check("flush_out_valid", 512'(out_valid), 512'(0));
    check("flush_in_ready", 512'(in_ready), 512'(1));
    check("flush_no_xfer", 512'(dut_xfers.size()), 512'(0));

    // Random traffic with a small PTC alphabet to provoke frequent collisions.
    for (int t = 0; t < 400; t++) begin
      d = {$urandom, $urandom};
      p = '0;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(1, 0) == 1) p[b*16 +: 16] = 16'($urandom_range(6, 1));
      cycle(($urandom_range(9, 0) < 6), d, p, ($urandom_range(1, 0) == 1),
            ($urandom_range(49, 0) == 0));
    end

    // Asynchronous reset between edges with entries pending.
    cycle(1'b1, 64'h1234, slice_ptc(5, 16'h0055), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    model_reset();
    check("mid_rst_in_ready", 512'(in_ready), 512'(1));
    check("mid_rst_out_valid", 512'(out_valid), 512'(0));
    check("mid_rst_pptc", prospective_ptc, 512'(0));
    @(negedge clk);
    clr = 1'b1;
    idle(1'b0);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
